// File: rtl/fifo_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// fifo_cmd_sequencer
//
// UART command sequencer for the shared synchronous FIFO. Command bytes come
// in from the UART receiver. The block drives the FIFO write and read ports and
// the UART transmitter strobe. It is the only master of the FIFO ports.
//
// Commands (low byte of uart_rx_data_in, accepted only while idle):
//   'w' L : write L bytes of a free-running pattern (seed, seed+1, ...)
//   'r'   : drain the FIFO to the UART transmitter
//   'c'   : flush the FIFO (read and discard) and clear err_out
//   's'   : send a status byte {err_out, fifo_full_in, fifo_empty_in, 5'b0}
// Any other byte is ignored. Any byte that arrives while busy is dropped.
//
// Ports
//   clk_in            in   system clock, rising edge
//   n_rst             in   asynchronous active-low reset
//   uart_rx_valid_in  in   1-cycle strobe, uart_rx_data_in valid
//   uart_rx_data_in   in   received byte (DATA_BITS wide, command in [7:0])
//   uart_tx_ready_in  in   transmitter idle
//   uart_tx_en        out  1-cycle send strobe
//   uart_tx_data_out  out  byte to send, valid with uart_tx_en
//   fifo_full_in      in   FIFO full
//   fifo_empty_in     in   FIFO empty
//   fifo_rd_data_in   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_wr_en        out  FIFO write strobe
//   fifo_wr_data_out  out  FIFO write data
//   fifo_rd_en        out  FIFO read strobe
//   busy_out          out  high whenever the sequencer is not idle
//   err_out           out  sticky, set when a write burst is cut short by a
//                          full FIFO, cleared by a completed flush
//   state_dbg         out  current FSM state encoding, for observation only
//
// Handshakes
//   The rx side has no backpressure. A byte is taken when uart_rx_valid_in is
//   high on a rising edge and the FSM is in a state that wants a byte.
//   On the tx side, uart_tx_en is only raised when uart_tx_ready_in was high
//   on the edge before it. The transmitter keeps ready high through the strobe
//   cycle and drops it on the following cycle. FIFO strobes are only issued
//   against the full/empty status of the cycle in which they are decided. Each
//   strobe is followed by a gap cycle, so that status has settled before the
//   next decision is made.
//
// All outputs are registered, so every strobe appears one cycle after the
// state that decides it.
// -----------------------------------------------------------------------------
module fifo_cmd_sequencer #(
    parameter int                   DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] SEED_INIT = '0
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 uart_rx_valid_in,
    input  logic [DATA_BITS-1:0] uart_rx_data_in,
    input  logic                 uart_tx_ready_in,
    output logic                 uart_tx_en,
    output logic [DATA_BITS-1:0] uart_tx_data_out,
    input  logic                 fifo_full_in,
    input  logic                 fifo_empty_in,
    input  logic [DATA_BITS-1:0] fifo_rd_data_in,
    output logic                 fifo_wr_en,
    output logic [DATA_BITS-1:0] fifo_wr_data_out,
    output logic                 fifo_rd_en,
    output logic                 busy_out,
    output logic                 err_out,
    output logic [3:0]           state_dbg
);

    localparam logic [7:0] CMD_WRITE  = 8'h77;  // 'w'
    localparam logic [7:0] CMD_READ   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_FLUSH  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STATUS = 8'h73;  // 's'

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        GET_LEN = 4'd1,
        WR_PUSH = 4'd2,
        WR_GAP  = 4'd3,
        RD_REQ  = 4'd4,
        RD_WAIT = 4'd5,
        RD_SEND = 4'd6,
        RD_HOLD = 4'd7,
        FLUSH   = 4'd8,
        ST_SEND = 4'd9,
        ST_HOLD = 4'd10
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] seed;        // next pattern value, persists across bursts
    logic [7:0]           remaining;   // bytes still to write in this burst
    logic                 flush_gap;   // flush just issued a read, skip one cycle
    logic [DATA_BITS-1:0] status_word;

    assign state_dbg = state;

    // Status byte, zero-extended when DATA_BITS is wider than 8.
    always_comb begin
        status_word      = '0;
        status_word[7:5] = {err_out, fifo_full_in, fifo_empty_in};
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            seed             <= SEED_INIT;
            remaining        <= '0;
            flush_gap        <= 1'b0;
            uart_tx_en       <= 1'b0;
            uart_tx_data_out <= '0;
            fifo_wr_en       <= 1'b0;
            fifo_wr_data_out <= '0;
            fifo_rd_en       <= 1'b0;
            busy_out         <= 1'b0;
            err_out          <= 1'b0;
        end else begin
            // Strobes last a single cycle unless a state re-asserts them.
            uart_tx_en <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (uart_rx_valid_in) begin
                        case (uart_rx_data_in[7:0])
                            CMD_WRITE: begin
                                state    <= GET_LEN;
                                busy_out <= 1'b1;
                            end
                            CMD_READ: begin
                                state    <= RD_REQ;
                                busy_out <= 1'b1;
                            end
                            CMD_FLUSH: begin
                                state     <= FLUSH;
                                flush_gap <= 1'b0;
                                busy_out  <= 1'b1;
                            end
                            CMD_STATUS: begin
                                state    <= ST_SEND;
                                busy_out <= 1'b1;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end

                GET_LEN: begin
                    if (uart_rx_valid_in) begin
                        if (uart_rx_data_in[7:0] == 8'd0) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end else begin
                            remaining <= uart_rx_data_in[7:0];
                            state     <= WR_PUSH;
                        end
                    end
                end

                WR_PUSH: begin
                    if (!fifo_full_in) begin
                        fifo_wr_en       <= 1'b1;
                        fifo_wr_data_out <= seed;
                        seed             <= seed + DATA_BITS'(1);
                        remaining        <= remaining - 8'd1;
                        state            <= WR_GAP;
                    end else begin
                        // Burst cut short: record it and give up on the rest.
                        err_out  <= 1'b1;
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end

                WR_GAP: begin
                    // The write strobe is visible in this cycle. The FIFO's
                    // full flag reflects it by the next WR_PUSH decision.
                    if (remaining == 8'd0) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        state <= WR_PUSH;
                    end
                end

                RD_REQ: begin
                    if (fifo_empty_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (uart_tx_ready_in) begin
                        fifo_rd_en <= 1'b1;
                        state      <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    // fifo_rd_en is on the port during this cycle. The FIFO
                    // presents the word during the next cycle.
                    state <= RD_SEND;
                end

                RD_SEND: begin
                    // The read word is valid now. Capture it straight into
                    // the tx data register together with the send strobe.
                    uart_tx_en       <= 1'b1;
                    uart_tx_data_out <= fifo_rd_data_in;
                    state            <= RD_HOLD;
                end

                RD_HOLD: begin
                    // Ready is still high in the strobe cycle. Do not look at
                    // it again until the transmitter has had a chance to drop it.
                    state <= RD_REQ;
                end

                FLUSH: begin
                    if (flush_gap) begin
                        flush_gap <= 1'b0;
                    end else if (fifo_empty_in) begin
                        err_out  <= 1'b0;
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        fifo_rd_en <= 1'b1;
                        flush_gap  <= 1'b1;
                    end
                end

                ST_SEND: begin
                    if (uart_tx_ready_in) begin
                        uart_tx_en       <= 1'b1;
                        uart_tx_data_out <= status_word;
                        state            <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fifo_cmd_sequencer
//
// Bench for fifo_cmd_sequencer. It provides a behavioural sync FIFO with a
// runtime-selectable depth and a UART transmitter with a configurable busy
// time. A command-level reference model (queue of FIFO contents, seed, sticky
// error) predicts every FIFO write and UART byte. The model pushes those
// predictions into expected queues, and a negedge monitor pops and compares
// them whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_fifo_cmd_sequencer;

    localparam int         W           = 8;
    localparam int         IDLE_BUDGET = 3000;
    localparam logic [7:0] CMD_W       = 8'h77;
    localparam logic [7:0] CMD_R       = 8'h72;
    localparam logic [7:0] CMD_C       = 8'h63;
    localparam logic [7:0] CMD_S       = 8'h73;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    initial forever #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         tx_ready;
    logic         uart_tx_en;
    logic [W-1:0] uart_tx_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_wr_en;
    logic [W-1:0] fifo_wr_data;
    logic         fifo_rd_en;
    logic         busy_out;
    logic         err_out;
    logic [3:0]   state_dbg;

    fifo_cmd_sequencer #(.DATA_BITS(W), .SEED_INIT(8'h00)) dut (
        .clk_in           (clk),
        .n_rst            (n_rst),
        .uart_rx_valid_in (rx_valid),
        .uart_rx_data_in  (rx_data),
        .uart_tx_ready_in (tx_ready),
        .uart_tx_en       (uart_tx_en),
        .uart_tx_data_out (uart_tx_data),
        .fifo_full_in     (fifo_full),
        .fifo_empty_in    (fifo_empty),
        .fifo_rd_data_in  (fifo_rd_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data_out (fifo_wr_data),
        .fifo_rd_en       (fifo_rd_en),
        .busy_out         (busy_out),
        .err_out          (err_out),
        .state_dbg        (state_dbg)
    );

    // ---------------- environment: sync FIFO ----------------
    int           fifo_depth = 4;
    logic [W-1:0] env_q[$];
    int           fifo_count;
    logic         bd_en = 1'b0;       // backdoor preload of the environment FIFO
    logic [W-1:0] bd_data = '0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            env_q.delete();
            fifo_count   <= 0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en && env_q.size() > 0) fifo_rd_data <= env_q.pop_front();
            if (fifo_wr_en && env_q.size() < fifo_depth) env_q.push_back(fifo_wr_data);
            if (bd_en) env_q.push_back(bd_data);
            fifo_count <= env_q.size();
        end
    end

    assign fifo_full  = (fifo_count >= fifo_depth);
    assign fifo_empty = (fifo_count == 0);

    // ---------------- environment: UART transmitter ----------------
    int tx_delay = 2;    // cycles ready stays low after an accepted strobe
    int tx_cnt;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_ready <= 1'b1;
            tx_cnt   <= 0;
        end else if (uart_tx_en && tx_ready) begin
            tx_ready <= 1'b0;
            tx_cnt   <= tx_delay - 1;
        end else if (!tx_ready) begin
            if (tx_cnt == 0) tx_ready <= 1'b1;
            else             tx_cnt   <= tx_cnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_wr_q[$];
    logic [W-1:0] exp_tx_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    int cyc         = 0;
    int last_wr_cyc = -10;
    int rd_total    = 0;
    int tx_total    = 0;

    always @(negedge clk) begin
        cyc++;
        if (n_rst === 1'b1) begin
            if (fifo_wr_en) begin
                check("wr_rd_exclusive", fifo_rd_en, 0);
                check("wr_while_full", fifo_full, 0);
                check("wr_spacing_ge2", (cyc - last_wr_cyc) >= 2, 1);
                last_wr_cyc = cyc;
                check("wr_expected", exp_wr_q.size() > 0, 1);
                if (exp_wr_q.size() > 0) check("wr_data", fifo_wr_data, exp_wr_q.pop_front());
            end
            if (fifo_rd_en) begin
                rd_total++;
                check("rd_while_empty", fifo_empty, 0);
            end
            if (uart_tx_en) begin
                tx_total++;
                check("tx_when_ready", tx_ready, 1);
                check("tx_expected", exp_tx_q.size() > 0, 1);
                if (exp_tx_q.size() > 0) check("tx_data", uart_tx_data, exp_tx_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] ref_q[$];
    logic [W-1:0] ref_seed = 8'h00;
    logic         ref_err  = 1'b0;

    task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] len);
        int free;
        int n;
        logic [7:0] st;
        case (cmd)
            CMD_W: begin
                free = fifo_depth - ref_q.size();
                n    = (int'(len) > free) ? free : int'(len);
                for (int i = 0; i < n; i++) begin
                    exp_wr_q.push_back(ref_seed);
                    ref_q.push_back(ref_seed);
                    ref_seed = ref_seed + 8'd1;
                end
                if (int'(len) > free) ref_err = 1'b1;
            end
            CMD_R: begin
                foreach (ref_q[i]) exp_tx_q.push_back(ref_q[i]);
                ref_q.delete();
            end
            CMD_C: begin
                ref_q.delete();
                ref_err = 1'b0;
            end
            CMD_S: begin
                st = {ref_err, (ref_q.size() >= fifo_depth), (ref_q.size() == 0), 5'b00000};
                exp_tx_q.push_back(st);
            end
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic preload(input logic [7:0] b);
        bd_en   = 1'b1;
        bd_data = b;
        ref_q.push_back(b);
        tick();
        bd_en = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_out === 1'b1 && n < IDLE_BUDGET) begin
            tick();
            n++;
        end
        check("cmd_completes", busy_out, 0);
        repeat (2) tick();
    endtask

    task automatic post_checks();
        check("wr_all_seen", exp_wr_q.size(), 0);
        check("tx_all_seen", exp_tx_q.size(), 0);
        check("err_out", err_out, ref_err);
        check("fifo_level", fifo_count, ref_q.size());
    endtask

    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] len);
        model_cmd(cmd, len);
        send_rx(cmd);
        if (cmd == CMD_W) send_rx(len);
        wait_idle();
        post_checks();
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_en", uart_tx_en, 0);
        check("rst_tx_data", uart_tx_data, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy_out, 0);
        check("rst_err", err_out, 0);
        check("rst_state", state_dbg, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rd0;
        int tx0;
        int busy_cnt;
        logic [7:0] c;

        rx_valid = 1'b0;
        rx_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        n_rst = 1'b1;
        tick();
        check("idle_after_reset", busy_out, 0);

        // Basic bursts, and the seed persisting across bursts.
        do_cmd(CMD_W, 8'd4);
        do_cmd(CMD_C, 8'd0);
        do_cmd(CMD_W, 8'd2);
        do_cmd(CMD_C, 8'd0);

        // Move the seed to 0xFF, then cross the wrap.
        fifo_depth = 512;
        do_cmd(CMD_W, 8'd249);
        do_cmd(CMD_W, 8'd2);
        do_cmd(CMD_C, 8'd0);
        fifo_depth = 4;

        // A zero-length write does nothing.
        do_cmd(CMD_W, 8'd0);

        // Truncation: depth 4 holding 3 entries, ask for 5.
        preload(8'h11);
        preload(8'h22);
        preload(8'h33);
        rd0 = rd_total;
        do_cmd(CMD_W, 8'd5);
        check("trunc_err_set", err_out, 1);
        do_cmd(CMD_S, 8'd0);

        // Drain the 4 entries with a slow transmitter.
        tx_delay = 3;
        do_cmd(CMD_R, 8'd0);

        // Flush 3 entries while extra bytes arrive, which must be dropped.
        preload(8'h44);
        preload(8'h55);
        preload(8'h66);
        rd0 = rd_total;
        tx0 = tx_total;
        model_cmd(CMD_C, 8'd0);
        send_rx(CMD_C);
        send_rx(CMD_S);
        send_rx(CMD_W);
        wait_idle();
        post_checks();
        check("flush_rd_pulses", rd_total - rd0, 3);
        check("flush_no_tx", tx_total - tx0, 0);
        do_cmd(CMD_S, 8'd0);

        // Drain A5,5A with ready held low for 3 cycles per byte.
        preload(8'hA5);
        preload(8'h5A);
        rd0 = rd_total;
        tx0 = tx_total;
        do_cmd(CMD_R, 8'd0);
        check("drain_rd_pulses", rd_total - rd0, 2);
        check("drain_tx_bytes", tx_total - tx0, 2);

        // 'r' on an empty FIFO: one busy cycle, no transmit.
        tx0 = tx_total;
        send_rx(CMD_R);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy_out === 1'b1) busy_cnt++;
            tick();
        end
        check("r_empty_busy_cycles", busy_cnt, 1);
        check("r_empty_no_tx", tx_total - tx0, 0);

        // Randomised command stream.
        for (int k = 0; k < 40; k++) begin
            tx_delay = $urandom_range(1, 4);
            case ($urandom_range(0, 4))
                0: do_cmd(CMD_W, 8'($urandom_range(0, 6)));
                1: do_cmd(CMD_R, 8'd0);
                2: do_cmd(CMD_C, 8'd0);
                3: do_cmd(CMD_S, 8'd0);
                default: begin
                    c = 8'($urandom_range(0, 8'h60));
                    do_cmd(c, 8'd0);
                end
            endcase
        end

        // Reset in the middle of a burst.
        do_cmd(CMD_C, 8'd0);
        fifo_depth = 64;
        model_cmd(CMD_W, 8'd20);
        send_rx(CMD_W);
        send_rx(8'd20);
        repeat (6) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs();
        check("mid_burst_partial", (exp_wr_q.size() > 0) && (exp_wr_q.size() < 20), 1);
        exp_wr_q.delete();
        exp_tx_q.delete();
        ref_q.delete();
        ref_seed = 8'h00;
        ref_err  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();
        fifo_depth = 4;
        do_cmd(CMD_W, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
